// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV32I decode stage.
// Contents:
//   - opcode constants
//   - ALU operation codes
//   - write-back select encodings
//   - the decoded-bundle struct passed from the decoder to the pipeline register
package rv_decode_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned IMM_W     = 32;
    localparam int unsigned ALU_OP_W  = 5;
    localparam int unsigned OPC_W     = 7;

    // Major opcodes (full 7 bits, so inst[1:0] != 2'b11 never matches)
    localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

    // ALU op codes; the legacy decoder's values are kept unchanged
    localparam logic [ALU_OP_W-1:0] ALU_NONE  = 5'b00000;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ   = 5'b10001;
    localparam logic [ALU_OP_W-1:0] ALU_LOAD  = 5'b10100;
    localparam logic [ALU_OP_W-1:0] ALU_JALR  = 5'b10100;
    localparam logic [ALU_OP_W-1:0] ALU_STORE = 5'b10101;
    localparam logic [ALU_OP_W-1:0] ALU_ADDI  = 5'b01100;
    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 5'b01101;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 5'b01110;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 5'b00110;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 5'b01001;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 5'b00101;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 5'b00100;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 5'b01000;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 5'b01010;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 5'b01011;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 5'b00111;
    localparam logic [ALU_OP_W-1:0] ALU_BNE   = 5'b10010;
    localparam logic [ALU_OP_W-1:0] ALU_BLT   = 5'b10011;
    localparam logic [ALU_OP_W-1:0] ALU_BGE   = 5'b10110;
    localparam logic [ALU_OP_W-1:0] ALU_BLTU  = 5'b10111;
    localparam logic [ALU_OP_W-1:0] ALU_BGEU  = 5'b11000;
    localparam logic [ALU_OP_W-1:0] ALU_LUI   = 5'b11001;
    localparam logic [ALU_OP_W-1:0] ALU_AUIPC = 5'b11010;
    localparam logic [ALU_OP_W-1:0] ALU_JAL   = 5'b11011;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    // Decoded instruction bundle; imm is the 32-bit sign-carrying immediate
    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [IMM_W-1:0]     imm;
        logic [ALU_OP_W-1:0]  alu_op;
        logic                 pc_sel;
        logic                 alu_src1;
        logic                 alu_src2;
        logic                 reg_we;
        logic                 mem_we;
        logic [2:0]           mem_size;
        wb_sel_e              wb_sel;
        logic                 illegal;
    } dec_bundle_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I decoder.
// Ports:
//   inst_i - instruction word
//   dec_o  - decoded bundle (illegal encodings yield a zeroed control set with illegal=1)
// FULL_RV32I=0 restricts decoding to the legacy subset.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter bit FULL_RV32I = 1'b1
) (
    input  logic [INST_W-1:0] inst_i,
    output dec_bundle_t       dec_o
);

    logic [OPC_W-1:0] opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [IMM_W-1:0] imm_i;
    logic [IMM_W-1:0] imm_s;
    logic [IMM_W-1:0] imm_b;
    logic [IMM_W-1:0] imm_u;
    logic [IMM_W-1:0] imm_j;
    logic             illegal;
    logic             legacy;
    dec_bundle_t      d;

    assign opc   = inst_i[6:0];
    assign f3    = inst_i[14:12];
    assign f7    = inst_i[31:25];
    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Per-opcode decode; legacy marks ops that existed in the original decoder
    always_comb begin
        d         = '0;
        illegal   = 1'b0;
        legacy    = 1'b0;
        d.rs1     = inst_i[19:15];
        d.rs2     = inst_i[24:20];
        d.rd      = inst_i[11:7];
        d.wb_sel  = WB_ALU;
        case (opc)
            OPC_LOAD: begin
                d.imm      = imm_i;
                d.alu_op   = ALU_LOAD;
                d.alu_src2 = 1'b1;
                d.reg_we   = 1'b1;
                d.wb_sel   = WB_MEM;
                d.mem_size = f3;
                illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                legacy     = (f3 == 3'b010);
            end
            OPC_STORE: begin
                d.imm      = imm_s;
                d.alu_op   = ALU_STORE;
                d.alu_src2 = 1'b1;
                d.mem_we   = 1'b1;
                d.mem_size = f3;
                illegal    = (f3 > 3'b010);
                legacy     = (f3 == 3'b010);
            end
            OPC_BRANCH: begin
                d.imm      = imm_b;
                d.pc_sel   = 1'b1;
                d.alu_src1 = 1'b1;
                d.alu_src2 = 1'b1;
                legacy     = (f3 == 3'b000);
                case (f3)
                    3'b000:  d.alu_op = ALU_BEQ;
                    3'b001:  d.alu_op = ALU_BNE;
                    3'b100:  d.alu_op = ALU_BLT;
                    3'b101:  d.alu_op = ALU_BGE;
                    3'b110:  d.alu_op = ALU_BLTU;
                    3'b111:  d.alu_op = ALU_BGEU;
                    default: illegal  = 1'b1;
                endcase
            end
            OPC_JALR: begin
                d.imm      = imm_i;
                d.alu_op   = ALU_JALR;
                d.pc_sel   = 1'b1;
                d.alu_src2 = 1'b1;
                d.reg_we   = 1'b1;
                d.wb_sel   = WB_PC4;
                illegal    = (f3 != 3'b000);
                legacy     = 1'b1;
            end
            OPC_JAL: begin
                d.imm      = imm_j;
                d.alu_op   = ALU_JAL;
                d.pc_sel   = 1'b1;
                d.alu_src1 = 1'b1;
                d.alu_src2 = 1'b1;
                d.reg_we   = 1'b1;
                d.wb_sel   = WB_PC4;
            end
            OPC_LUI: begin
                d.imm      = imm_u;
                d.alu_op   = ALU_LUI;
                d.alu_src2 = 1'b1;
                d.reg_we   = 1'b1;
            end
            OPC_AUIPC: begin
                d.imm      = imm_u;
                d.alu_op   = ALU_AUIPC;
                d.alu_src1 = 1'b1;
                d.alu_src2 = 1'b1;
                d.reg_we   = 1'b1;
            end
            OPC_OP_IMM: begin
                d.imm      = imm_i;
                d.alu_src2 = 1'b1;
                d.reg_we   = 1'b1;
                legacy     = (f3 == 3'b000);
                case (f3)
                    3'b000: d.alu_op = ALU_ADDI;
                    3'b010: d.alu_op = ALU_SLT;
                    3'b011: d.alu_op = ALU_SLTU;
                    3'b100: d.alu_op = ALU_XOR;
                    3'b110: d.alu_op = ALU_OR;
                    3'b111: d.alu_op = ALU_AND;
                    // Shift-immediates reuse the upper bits as a funct7 selector
                    3'b001: begin
                        d.alu_op = ALU_SLL;
                        illegal  = (f7 != 7'b0000000);
                    end
                    default: begin
                        if (f7 == 7'b0000000)      d.alu_op = ALU_SRL;
                        else if (f7 == 7'b0100000) d.alu_op = ALU_SRA;
                        else                       illegal  = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                d.reg_we = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d.alu_op = ALU_ADD;
                        3'b001:  d.alu_op = ALU_SLL;
                        3'b010:  d.alu_op = ALU_SLT;
                        3'b011:  d.alu_op = ALU_SLTU;
                        3'b100:  d.alu_op = ALU_XOR;
                        3'b101:  d.alu_op = ALU_SRL;
                        3'b110:  d.alu_op = ALU_OR;
                        default: d.alu_op = ALU_AND;
                    endcase
                    legacy = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b101) ||
                             (f3 == 3'b110) || (f3 == 3'b111);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.alu_op = ALU_SUB;
                    legacy   = 1'b1;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.alu_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            // fence / ecall / ebreak: legal, no architectural side effects here
            OPC_MISC_MEM, OPC_SYSTEM: begin
                d.imm = imm_i;
            end
            default: illegal = 1'b1;
        endcase

        if (!FULL_RV32I && !legacy) illegal = 1'b1;

        // Illegal bundles carry no control effects
        if (illegal) begin
            d.imm      = '0;
            d.alu_op   = ALU_NONE;
            d.pc_sel   = 1'b0;
            d.alu_src1 = 1'b0;
            d.alu_src2 = 1'b0;
            d.reg_we   = 1'b0;
            d.mem_we   = 1'b0;
            d.mem_size = 3'b000;
            d.wb_sel   = WB_ALU;
        end
        if (d.rd == 5'd0) d.reg_we = 1'b0;
        d.illegal = illegal;
    end

    assign dec_o = d;

endmodule

// File: rtl/rv_decode_stage.sv
// Decode pipeline stage between fetch and execute.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   in_*          - fetch-side valid/ready handshake
//   inst_i, pc_i  - incoming instruction and its PC
//   flush_i       - kill held and incoming instruction
//   out_*         - execute-side valid/ready handshake
//   *_o           - registered decoded bundle
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALUOP_W    = 5,
    parameter bit          FULL_RV32I = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               flush_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    pc_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [4:0]         rd_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               pc_sel_o,
    output logic               alu_src1_o,
    output logic               alu_src2_o,
    output logic               reg_we_o,
    output logic               mem_we_o,
    output logic [2:0]         mem_size_o,
    output logic [1:0]         wb_sel_o,
    output logic               illegal_o
);

    dec_bundle_t     dec;
    dec_bundle_t     bundle_d, bundle_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic            valid_d, valid_q;
    logic            accept;

    rv_decode_comb #(
        .FULL_RV32I(FULL_RV32I)
    ) u_decode (
        .inst_i(inst_i),
        .dec_o (dec)
    );

    assign in_ready = rst && !flush_i && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Flush beats accept, accept beats drain, otherwise hold
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        pc_d     = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            pc_d     = pc_i;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
        end
    end

    assign out_valid  = valid_q;
    assign pc_o       = pc_q;
    assign rs1_o      = bundle_q.rs1;
    assign rs2_o      = bundle_q.rs2;
    assign rd_o       = bundle_q.rd;
    assign imm_o      = XLEN'($signed(bundle_q.imm));
    assign alu_op_o   = ALUOP_W'(bundle_q.alu_op);
    assign pc_sel_o   = bundle_q.pc_sel;
    assign alu_src1_o = bundle_q.alu_src1;
    assign alu_src2_o = bundle_q.alu_src2;
    assign reg_we_o   = bundle_q.reg_we;
    assign mem_we_o   = bundle_q.mem_we;
    assign mem_size_o = bundle_q.mem_size;
    assign wb_sel_o   = bundle_q.wb_sel;
    assign illegal_o  = bundle_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a full-ISA instance and a legacy-subset
// instance share stimulus; expected values are hand-computed constants.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        out_ready;

    logic        in_ready, out_valid, pc_sel_o, alu_src1_o, alu_src2_o;
    logic        reg_we_o, mem_we_o, illegal_o;
    logic [31:0] pc_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o, alu_op_o;
    logic [2:0]  mem_size_o;
    logic [1:0]  wb_sel_o;

    logic        l_in_ready, l_out_valid, l_pc_sel, l_alu_src1, l_alu_src2;
    logic        l_reg_we, l_mem_we, l_illegal;
    logic [31:0] l_pc, l_imm;
    logic [4:0]  l_rs1, l_rs2, l_rd, l_alu_op;
    logic [2:0]  l_mem_size;
    logic [1:0]  l_wb_sel;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .ALUOP_W(5), .FULL_RV32I(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
        .alu_op_o(alu_op_o), .pc_sel_o(pc_sel_o), .alu_src1_o(alu_src1_o),
        .alu_src2_o(alu_src2_o), .reg_we_o(reg_we_o), .mem_we_o(mem_we_o),
        .mem_size_o(mem_size_o), .wb_sel_o(wb_sel_o), .illegal_o(illegal_o)
    );

    rv_decode_stage #(.XLEN(32), .ALUOP_W(5), .FULL_RV32I(1'b0)) dut_leg (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i),
        .out_valid(l_out_valid), .out_ready(out_ready), .pc_o(l_pc),
        .rs1_o(l_rs1), .rs2_o(l_rs2), .rd_o(l_rd), .imm_o(l_imm),
        .alu_op_o(l_alu_op), .pc_sel_o(l_pc_sel), .alu_src1_o(l_alu_src1),
        .alu_src2_o(l_alu_src2), .reg_we_o(l_reg_we), .mem_we_o(l_mem_we),
        .mem_size_o(l_mem_size), .wb_sel_o(l_wb_sel), .illegal_o(l_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive inputs on the falling edge
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        inst_i    = ins;
        pc_i      = pc;
        out_ready = rdy;
        flush_i   = fl;
    endtask

    // Let one rising edge pass, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; inst_i = '0; pc_i = '0;
        flush_i = 1'b0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_pc",        pc_o,           32'd0);
        check("rst_imm",       imm_o,          32'd0);
        check("rst_alu_op",    32'(alu_op_o),  32'd0);

        // addi x1,x0,5
        drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("addi_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("addi_valid",    32'(out_valid),  32'd1);
        check("addi_pc",       pc_o,            32'h100);
        check("addi_rd",       32'(rd_o),       32'd1);
        check("addi_imm",      imm_o,           32'd5);
        check("addi_alu_op",   32'(alu_op_o),   32'b01100);
        check("addi_reg_we",   32'(reg_we_o),   32'd1);
        check("addi_src2",     32'(alu_src2_o), 32'd1);
        check("addi_illegal",  32'(illegal_o),  32'd0);
        check("addi_leg_ill",  32'(l_illegal),  32'd0);

        // sw x2,8(x1)
        drive(1'b1, 32'h0020A423, 32'h104, 1'b1, 1'b0);
        tick();
        check("sw_rs1",      32'(rs1_o),      32'd1);
        check("sw_rs2",      32'(rs2_o),      32'd2);
        check("sw_imm",      imm_o,           32'd8);
        check("sw_mem_we",   32'(mem_we_o),   32'd1);
        check("sw_reg_we",   32'(reg_we_o),   32'd0);
        check("sw_mem_size", 32'(mem_size_o), 32'b010);
        check("sw_alu_op",   32'(alu_op_o),   32'b10101);

        // beq x1,x2,-4
        drive(1'b1, 32'hFE208EE3, 32'h108, 1'b1, 1'b0);
        tick();
        check("beq_imm",    imm_o,           32'hFFFFFFFC);
        check("beq_pc_sel", 32'(pc_sel_o),   32'd1);
        check("beq_src1",   32'(alu_src1_o), 32'd1);
        check("beq_alu_op", 32'(alu_op_o),   32'b10001);
        check("beq_reg_we", 32'(reg_we_o),   32'd0);

        // lui x5,0x12345 (legal in full, illegal in legacy)
        drive(1'b1, 32'h123452B7, 32'h10C, 1'b1, 1'b0);
        tick();
        check("lui_imm",       imm_o,         32'h12345000);
        check("lui_alu_op",    32'(alu_op_o), 32'b11001);
        check("lui_rd",        32'(rd_o),     32'd5);
        check("lui_reg_we",    32'(reg_we_o), 32'd1);
        check("lui_leg_valid", 32'(l_out_valid), 32'd1);
        check("lui_leg_ill",   32'(l_illegal),   32'd1);
        check("lui_leg_we",    32'(l_reg_we),    32'd0);
        check("lui_leg_pcsel", 32'(l_pc_sel),    32'd0);

        // All-ones word: unknown opcode
        drive(1'b1, 32'hFFFFFFFF, 32'h110, 1'b1, 1'b0);
        tick();
        check("ill_valid",  32'(out_valid), 32'd1);
        check("ill_flag",   32'(illegal_o), 32'd1);
        check("ill_reg_we", 32'(reg_we_o),  32'd0);
        check("ill_pc_sel", 32'(pc_sel_o),  32'd0);
        check("ill_alu_op", 32'(alu_op_o),  32'd0);
        check("ill_imm",    imm_o,          32'd0);

        // Back-pressure: add x3,x1,x2 offered while execute stalls
        drive(1'b1, 32'h002081B3, 32'h114, 1'b0, 1'b0);
        #1;
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_pc",       pc_o,           32'h110);
            check("bp_illegal",  32'(illegal_o), 32'd1);
            check("bp_in_ready", 32'(in_ready),  32'd0);
        end
        drive(1'b1, 32'h002081B3, 32'h114, 1'b1, 1'b0);
        tick();
        check("bp_add_pc",     pc_o,            32'h114);
        check("bp_add_alu_op", 32'(alu_op_o),   32'b01101);
        check("bp_add_src2",   32'(alu_src2_o), 32'd0);
        check("bp_add_rd",     32'(rd_o),       32'd3);
        drive(1'b0, 32'h002081B3, 32'h114, 1'b1, 1'b0);
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Flush with a held bundle and an incoming instruction
        drive(1'b1, 32'h00500093, 32'h118, 1'b1, 1'b0);
        tick();
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 32'h0020A423, 32'h11C, 1'b1, 1'b1);
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("fl_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("fl_dropped", 32'(out_valid), 32'd0);

        // nop (addi x0,x0,0): rd=0 suppresses write enable
        drive(1'b1, 32'h00000013, 32'h120, 1'b1, 1'b0);
        tick();
        check("nop_valid",  32'(out_valid), 32'd1);
        check("nop_reg_we", 32'(reg_we_o),  32'd0);

        // Reset during a stall
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("rs_hold_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_pc",    pc_o,           32'd0);
        check("rs_ready", 32'(in_ready),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Pipelined, parametrised successor to the single-cycle instruction decoder. It accepts one fetched instruction per cycle with a valid/ready handshake, decodes the full RV32I base set, and flags illegal encodings. Results are held in a registered decode/execute pipeline register. It sits between the fetch stage and the execute stage, and supports back-pressure and flush on taken branches or jumps.

Parameters:
XLEN, 32, datapath width for the PC and immediate outputs; immediates are sign-extended to XLEN.
ALUOP_W, 5, width of the ALU operation code.
FULL_RV32I, 1, 1 = decode all RV32I ops; 0 = legacy subset only (beq, lw, sw, addi, add, sub, xor, srl, or, and, jalr), all others illegal.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept
inst_i  in  32  instruction word
pc_i  in  XLEN  PC of inst_i
flush_i  in  1  kill the held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes the bundle
pc_o  out  XLEN  registered PC
rs1_o, rs2_o, rd_o  out  5 each  register indices
imm_o  out  XLEN  sign-extended immediate (I/S/B/U/J)
alu_op_o  out  ALUOP_W  operation code
pc_sel_o  out  1  1 for branch, jal, jalr
alu_src1_o  out  1  1 = PC operand (branch, jal, auipc)
alu_src2_o  out  1  0 = rs2 (R-type), 1 = imm
reg_we_o  out  1  register write enable
mem_we_o  out  1  store enable
mem_size_o  out  3  funct3 for loads and stores
wb_sel_o  out  2  00 ALU, 01 memory, 10 PC+4
illegal_o  out  1  illegal encoding

Behaviour:
- Reset (rst=0 at a clock edge): out_valid=0 and every output register=0. in_ready=0 while rst=0.
- in_ready = rst && !flush_i && (!out_valid || out_ready).
- Accept when in_valid && in_ready. On the next edge the bundle is registered and out_valid=1. Latency is exactly 1 cycle.
- If there is no accept and out_ready=1, out_valid goes to 0.
- If out_valid && !out_ready, all outputs hold stable and bit-exact.
- flush_i=1: out_valid=0 on the next edge and any incoming instruction is dropped. Flush has priority over accept and hold. The data registers may keep stale values.
- Immediates:
  - I: inst[31:20], sign-extended.
  - S: {inst[31:25], inst[11:7]}, sign-extended.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
  - R-type and illegal: imm_o=0.
- wb_sel_o: loads = 01; jal/jalr = 10; all others = 00.
- reg_we_o = 0 for stores, branches, illegal, or rd=0.
- Illegal is any of:
  - unknown opcode;
  - an R-type funct7 other than 0000000, or 0100000 with funct3 000/101;
  - load funct3 011/110/111;
  - store funct3 > 010;
  - branch funct3 010/011;
  - jalr funct3 != 000;
  - inst[1:0] != 11;
  - any non-legacy op when FULL_RV32I=0.
- An illegal instruction still flows as a valid bundle with illegal_o=1 and pc_sel_o, reg_we_o, mem_we_o, alu_op_o all 0.
- Reset asserted mid-stall clears out_valid regardless of out_ready.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode constants;
  - ALU op codes: legacy values unchanged (BEQ 10001, LOAD/JALR 10100, STORE 10101, ADDI 01100, ADD 01101, SUB 01110, XOR 00110, SRL 01001, OR 00101, AND 00100);
  - new codes: SLL 01000, SRA 01010, SLT 01011, SLTU 00111, BNE 10010, BLT 10011, BGE 10110, BLTU 10111, BGEU 11000, LUI 11001, AUIPC 11010, JAL 11011;
  - wb_sel encodings and the decoded-bundle struct.
- One combinational sub-module, rv_decode_comb (instruction in, bundle out). The top holds only the handshake and the pipeline register.

Test Plan:
- Reset release, then inst 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle: out_valid=1, rd=1, imm=5, alu_op=01100, reg_we=1, alu_src2=1.
- 0x0020A423 (sw x2,8(x1)) -> rs1=1, rs2=2, imm=8, mem_we=1, reg_we=0, mem_size=010.
- 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC, pc_sel=1, alu_src1=1, alu_op=10001. Then 0x123452B7 (lui x5) -> imm=0x12345000, alu_op=11001, rd=5.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen. After out_ready=1, the next instruction appears 1 cycle later with none lost or duplicated.
- flush_i pulsed with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the incoming instruction never appears.
- 0xFFFFFFFF, and with FULL_RV32I=0 lui 0x123452B7 -> illegal_o=1, reg_we=0, pc_sel=0. rst=0 during a stall -> out_valid=0 on the next edge.
